// File: rtl/icache_fetch_if.sv
// Bus bundle between the core fetch path, the instruction cache and the
// backing memory. The testbench or core side uses the master modport.
// The cache uses the slave modport.
//
// Memory handshake (req/rvalid): mem_req and mem_addr are raised by the cache
// and held stable until mem_rvalid=1 is seen on a rising edge. That edge
// completes the request and captures mem_rdata. mem_req may stay high
// back-to-back for the next word. mem_rvalid has no meaning while mem_req=0
// and is ignored then.
interface icache_fetch_if;
   logic        fetch_en;
   logic [15:0] fetch_addr;
   logic [15:0] instr;
   logic        instr_valid;
   logic        invalidate;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   modport master (
      output fetch_en, fetch_addr, invalidate, mem_rdata, mem_rvalid,
      input  instr, instr_valid, mem_req, mem_addr, hit_cnt, miss_cnt
   );

   modport slave (
      input  fetch_en, fetch_addr, invalidate, mem_rdata, mem_rvalid,
      output instr, instr_valid, mem_req, mem_addr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache. A hit is answered combinationally
// in the same cycle. A miss stalls the core while a fill FSM fetches the
// whole line word by word from the backing memory. The cache also keeps
// saturating hit and miss counters.
module icache_fetch #(
   parameter int NUM_SETS       = 8,
   parameter int WORDS_PER_LINE = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   icache_fetch_if.slave bus,
   output logic [0:0]    dbg_state_o
);

   localparam int IW = $clog2(NUM_SETS);
   localparam int OW = $clog2(WORDS_PER_LINE);
   localparam int TW = 16 - 1 - OW - IW;
   localparam int BW = TW + IW;

   localparam logic [0:0]    S_IDLE = 1'b0;
   localparam logic [0:0]    S_FILL = 1'b1;
   localparam logic [OW-1:0] K_LAST = OW'(WORDS_PER_LINE - 1);

   // Address split of the current PC
   logic [OW-1:0] offset_w;
   logic [IW-1:0] index_w;
   logic [TW-1:0] tag_w;

   assign offset_w = bus.fetch_addr[OW:1];
   assign index_w  = bus.fetch_addr[OW+IW:OW+1];
   assign tag_w    = bus.fetch_addr[15:OW+IW+1];

   // Storage. Data and tags need no reset because valid bits gate every use.
   logic [15:0]         data_q [NUM_SETS*WORDS_PER_LINE];
   logic [TW-1:0]       tag_q  [NUM_SETS];
   logic [NUM_SETS-1:0] valid_q, valid_d;

   logic [0:0]    state_q, state_d;
   logic [BW-1:0] fill_base_q, fill_base_d;
   logic [OW-1:0] k_q, k_d;
   logic          abort_q, abort_d;
   logic [15:0]   hit_cnt_q, hit_cnt_d;
   logic [15:0]   miss_cnt_q, miss_cnt_d;

   logic          hit_w;
   logic [IW-1:0] fill_idx_w;
   logic [TW-1:0] fill_tag_w;
   logic          last_word_w;

   assign fill_idx_w  = fill_base_q[IW-1:0];
   assign fill_tag_w  = fill_base_q[BW-1:IW];
   assign last_word_w = (k_q == K_LAST);

   // Lookup and core-facing outputs; hits only count while idle
   always_comb begin
      hit_w = (state_q == S_IDLE) && bus.fetch_en && valid_q[index_w]
              && (tag_q[index_w] == tag_w);
      bus.instr_valid = hit_w;
      bus.instr       = hit_w ? data_q[{index_w, offset_w}] : 16'h0000;
   end

   // Memory request is held for the whole fill; address zero while idle
   always_comb begin
      bus.mem_req  = (state_q == S_FILL);
      bus.mem_addr = (state_q == S_FILL) ? {fill_base_q, k_q, 1'b0} : 16'h0000;
   end

   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;
   assign dbg_state_o  = state_q;

   // Next-state logic for the fill FSM, valid bits and counters
   always_comb begin
      state_d     = state_q;
      fill_base_d = fill_base_q;
      k_d         = k_q;
      abort_d     = abort_q;
      valid_d     = valid_q;
      miss_cnt_d  = miss_cnt_q;
      hit_cnt_d   = (hit_w && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.invalidate) valid_d = '0;
            if (bus.fetch_en && !hit_w) begin
               state_d     = S_FILL;
               fill_base_d = bus.fetch_addr[15:OW+1];
               k_d         = '0;
               abort_d     = 1'b0;
               if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
         end
         S_FILL: begin
            // Invalidate during a fill poisons the line being fetched too
            if (bus.invalidate) begin
               valid_d = '0;
               abort_d = 1'b1;
            end
            if (bus.mem_rvalid) begin
               k_d = k_q + 1'b1;
               if (last_word_w) begin
                  state_d             = S_IDLE;
                  valid_d[fill_idx_w] = ~abort_q & ~bus.invalidate;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state with asynchronous reset; reset abandons any fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         fill_base_q <= '0;
         k_q         <= '0;
         abort_q     <= 1'b0;
         valid_q     <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         fill_base_q <= fill_base_d;
         k_q         <= k_d;
         abort_q     <= abort_d;
         valid_q     <= valid_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Line data and tag writes from accepted memory words
   always_ff @(posedge clk) begin
      if (state_q == S_FILL && bus.mem_rvalid) begin
         data_q[{fill_idx_w, k_q}] <= bus.mem_rdata;
         if (last_word_w) tag_q[fill_idx_w] <= fill_tag_w;
      end
   end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the single-cycle core's fetch path (PC) and a multi-cycle instruction backing memory.
- A hit returns the instruction combinationally in the same cycle, so the core is not stalled.
- A miss stalls the core by holding instr_valid low. A fill FSM then fetches the whole line one word at a time using a req/rvalid handshake.
- Also keeps saturating hit and miss counters for performance debugging.

Parameters:
- NUM_SETS, 8, number of lines; power of 2, ≥2; index width IW = log2(NUM_SETS).
- WORDS_PER_LINE, 8, 16-bit words per line; power of 2, ≥2; offset width OW = log2(WORDS_PER_LINE).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  core wants an instruction; driven 0 when the core is halted.
- fetch_addr  in  16  byte address (PC); bit 0 ignored.
- instr  out  16  instruction word; valid only when instr_valid=1.
- instr_valid  out  1  hit this cycle; the core advances PC only when this is 1.
- invalidate  in  1  one-cycle pulse that clears all valid bits.
- mem_req  out  1  read request to backing memory.
- mem_addr  out  16  word-aligned byte address of the requested word.
- mem_rdata  in  16  returned word.
- mem_rvalid  in  1  mem_rdata valid; completes the current request.
- hit_cnt  out  16  saturating hit counter.
- miss_cnt  out  16  saturating miss counter.

Behaviour:
- Address split: offset = fetch_addr[OW:1]; index = fetch_addr[OW+IW:OW+1]; tag = the remaining upper bits.
- Storage: data array NUM_SETS×WORDS_PER_LINE×16; tag array; one valid bit per line.
- Reset (async, rst_n=0):
  - all valid bits cleared; state IDLE.
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, hit_cnt=0, miss_cnt=0.
  - Reset during FILL abandons the fill; any later mem_rvalid is ignored while in IDLE.
- Hit definition: state IDLE, fetch_en=1, valid[index]=1, tag match.
- On a hit: instr_valid=1 and instr=data[index][offset], combinationally in the same cycle.
- In all other cases: instr_valid=0 and instr=0.
- FSM states: IDLE, FILL.
  - IDLE→FILL: fetch_en=1 and no hit. On that edge:
    - latch the line base address (tag, index) into fill_base;
    - set word counter k=0;
    - clear the abort flag;
    - increment miss_cnt.
  - In FILL:
    - mem_req=1; mem_addr = {fill_base, k, 1'b0}. Both stay stable until mem_rvalid=1.
    - When mem_rvalid=1: write mem_rdata to data[fill index][k]; then k=k+1.
    - mem_req stays high back-to-back between words. On the edge that accepts the last word, mem_req drops to 0.
    - When the last word (k=WORDS_PER_LINE-1) is accepted: write the tag, set valid = ~abort, return to IDLE.
  - The next cycle in IDLE re-evaluates fetch_addr; a hit is expected if the address is unchanged.
  - Miss penalty: 1 cycle + sum of per-word memory latencies.
  - mem_rvalid is ignored while in IDLE.
- No hit-under-miss: instr_valid=0 throughout FILL, even if fetch_addr changes to a resident line.
- Changes to fetch_addr during FILL do not alter the fill in progress.
- fetch_en=0: no miss is started and no counter changes. A fill already in progress continues.
- invalidate:
  - In IDLE: clears all valid bits on that edge.
  - A hit in that same cycle is still reported and counted, because the lookup uses pre-edge state.
  - In FILL: clears all valid bits and sets abort. The fill completes its handshakes, but the line is written with valid=0.
- Counters:
  - hit_cnt increments on every edge where a hit is reported.
  - miss_cnt increments once per IDLE→FILL transition.
  - Both saturate at 16'hFFFF.
- Aliasing: two addresses with the same index and different tags evict each other. Each access that misses incurs a full refill.

Test Plan:
- Cold miss: reset, fetch_en=1, fetch_addr=0x0004, memory returns word n = 0x1000+n with a 2-cycle rvalid delay → mem_addr steps 0x0000,0x0002,…,0x000E; instr_valid stays 0 for 1+8×2=17 cycles, then instr=0x1002 with instr_valid=1; miss_cnt=1.
- Sequential hits: after the cold fill, step fetch_addr 0x0000..0x000E by 2 → instr_valid=1 every cycle; instr=0x1000..0x1007; hit_cnt=8; mem_req stays 0.
- Conflict eviction: fetch 0x0000, then 0x0080 (same index, different tag), then 0x0000 → three misses, miss_cnt=3; line contents match each tag's memory.
- Invalidate during FILL: pulse invalidate at fill word 3 → all 8 handshakes still complete; the next fetch of the same address misses again; miss_cnt increments.
- Reset mid-fill: drop rst_n at word 5 → mem_req=0 immediately; the stale rvalid after release is ignored; a refetch is a clean 8-word fill.
- Halt/saturation: fetch_en=0 on a missing address → no mem_req, counters unchanged; preload hit_cnt near 16'hFFFF through hits → holds at 16'hFFFF.
